// File: rtl/ram_req_arbiter.sv
// rtl/ram_req_arbiter.sv - round-robin write/read arbiter in front of a single-port synchronous RAM
// Read credits cover the mem_re stage, the mem_rdata stage and the 2-entry response FIFO.
module ram_req_arbiter #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          rr_q, rr_d;
  logic          mem_we_q, mem_re_q;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rd_pend_q;
  logic [1:0]    outstanding_q, outstanding_d;
  logic [DW-1:0] fifo_q [2];
  logic          wptr_q, rptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          push, pop, rd_elig, grant_wr, grant_rd;

  assign pop     = (cnt_q != 2'd0) && rsp_ready;
  assign push    = rd_pend_q;
  // A pop this cycle returns its credit immediately.
  assign rd_elig = rd_valid && ((outstanding_q - {1'b0, pop}) < 2'd2);

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (wr_valid && rd_elig) begin
      grant_wr = !rr_q;
      grant_rd = rr_q;
    end else begin
      grant_wr = wr_valid;
      grant_rd = rd_elig;
    end
  end

  always_comb begin
    rr_d          = rr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    outstanding_d = outstanding_q + {1'b0, grant_rd} - {1'b0, pop};
    cnt_d         = cnt_q + {1'b0, push} - {1'b0, pop};
    if (grant_wr) begin
      rr_d        = 1'b1;
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
    end else if (grant_rd) begin
      rr_d       = 1'b0;
      mem_addr_d = rd_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q          <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_pend_q     <= 1'b0;
      outstanding_q <= 2'd0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      wptr_q        <= 1'b0;
      rptr_q        <= 1'b0;
      cnt_q         <= 2'd0;
    end else begin
      rr_q          <= rr_d;
      mem_we_q      <= grant_wr;
      mem_re_q      <= grant_rd;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_pend_q     <= mem_re_q;
      outstanding_q <= outstanding_d;
      cnt_q         <= cnt_d;
      if (push) begin
        fifo_q[wptr_q] <= mem_rdata;
        wptr_q         <= !wptr_q;
      end
      if (pop) begin
        rptr_q <= !rptr_q;
      end
    end
  end

  assign wr_ready  = grant_wr;
  assign rd_ready  = grant_rd;
  assign rsp_valid = (cnt_q != 2'd0);
  assign rsp_data  = fifo_q[rptr_q];
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_req_arbiter.sv
// tb/tb_ram_req_arbiter.sv - directed self-checking bench for ram_req_arbiter with a behavioural RAM
module tb_ram_req_arbiter;

  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, mem_addr;
  logic [DW-1:0] wr_data, rsp_data, mem_wdata, mem_rdata;
  logic          rsp_valid, rsp_ready, mem_we, mem_re;
  logic [DW-1:0] ram [2**AW];

  int n_cmp = 0;
  int n_err = 0;

  ram_req_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every push must find room in the response FIFO.
  always @(negedge clk) begin
    if (!rst && dut.rd_pend_q) chk("fifo_room", 32'(dut.cnt_q != 2'd2), 32'd1);
  end

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},    32'(mem_we),    32'd0);
    chk({tag, "_re"},    32'(mem_re),    32'd0);
    chk({tag, "_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
    chk({tag, "_rspd"},  32'(rsp_data),  32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; mem_rdata = '0;
    for (int i = 0; i < 2**AW; i++) ram[i] = 8'(8'h40 + i);
    @(negedge clk); @(negedge clk);
    chk_zero("rst");
    chk("rst_rdy", 32'({wr_ready, rd_ready}), 32'd0);
    rst = 1'b0;

    // single write
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 8'hA5; #1;
    chk("t1_wr_ready", 32'(wr_ready), 32'd1);
    chk("t1_rd_ready", 32'(rd_ready), 32'd0);
    @(negedge clk);
    chk("t1_mem_we", 32'(mem_we), 32'd1);
    chk("t1_mem_re", 32'(mem_re), 32'd0);
    chk("t1_mem_addr", 32'(mem_addr), 32'd5);
    chk("t1_mem_wdata", 32'(mem_wdata), 32'hA5);

    // write then read-after-write, 3-cycle latency
    wr_addr = 6'd7; wr_data = 8'h3C; #1;
    chk("t2_wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd7; #1;
    chk("t2_rd_ready", 32'(rd_ready), 32'd1);
    @(negedge clk);
    rd_valid = 1'b0;
    chk("t2_mem_re", 32'(mem_re), 32'd1);
    chk("t2_mem_addr", 32'(mem_addr), 32'd7);
    chk("t2_rspv_c1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t2_rspv_c2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t2_rspv_c3", 32'(rsp_valid), 32'd1);
    chk("t2_rsp_data", 32'(rsp_data), 32'h3C);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t2_rspv_pop", 32'(rsp_valid), 32'd0);

    // contended traffic alternates starting with write
    pulse_rst();
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_addr = 6'(16 + i); wr_data = 8'(i);
      rd_valid = 1'b1; rd_addr = 6'(i); #1;
      chk($sformatf("t3_grant%0d", i), 32'({wr_ready, rd_ready}), (i % 2 == 0) ? 32'd2 : 32'd1);
      @(negedge clk);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (5) @(negedge clk);

    // backpressure: only two reads accepted until a pop
    pulse_rst();
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 6'd0; #1;
    chk("t4_acc0", 32'(rd_ready), 32'd1);
    @(negedge clk);
    rd_addr = 6'd1; #1;
    chk("t4_acc1", 32'(rd_ready), 32'd1);
    @(negedge clk);
    rd_addr = 6'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_block%0d", i), 32'(rd_ready), 32'd0);
      @(negedge clk);
    end
    chk("t4_rspv0", 32'(rsp_valid), 32'd1);
    chk("t4_data0", 32'(rsp_data), 32'h40);
    rsp_ready = 1'b1; #1;
    chk("t4_acc2", 32'(rd_ready), 32'd1);
    @(negedge clk);
    chk("t4_rspv1", 32'(rsp_valid), 32'd1);
    chk("t4_data1", 32'(rsp_data), 32'h41);
    rd_addr = 6'd3; #1;
    chk("t4_acc3", 32'(rd_ready), 32'd1);
    @(negedge clk);
    rd_valid = 1'b0;
    chk("t4_rspv_gap", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t4_rspv2", 32'(rsp_valid), 32'd1);
    chk("t4_data2", 32'(rsp_data), 32'h42);
    @(negedge clk);
    chk("t5_pushpop_v", 32'(rsp_valid), 32'd1);
    chk("t5_pushpop_d", 32'(rsp_data), 32'h43);
    chk("t5_pushpop_cnt", 32'(dut.cnt_q), 32'd1);
    @(negedge clk);
    chk("t5_drained", 32'(rsp_valid), 32'd0);

    // reset with reads in flight, last grant a write
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 6'd8; #1;
    chk("t6_acc0", 32'(rd_ready), 32'd1);
    @(negedge clk);
    rd_addr = 6'd9; #1;
    chk("t6_acc1", 32'(rd_ready), 32'd1);
    @(negedge clk);
    rd_valid = 1'b0; wr_valid = 1'b1; wr_addr = 6'd30; wr_data = 8'h5A; #1;
    chk("t6_wr", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("t6_pre_we", 32'(mem_we), 32'd1);
    chk("t6_pre_rspv", 32'(rsp_valid), 32'd1);
    rst = 1'b1; #1;
    chk_zero("t6_async");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_norsp%0d", i), 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    wr_valid = 1'b1; rd_valid = 1'b1; #1;
    chk("t6_rr_reset", 32'({wr_ready, rd_ready}), 32'd2);
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
